// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited in-order memory requests feeding a 2-entry
// instruction FIFO, with branch redirect squashing and a sticky misaligned-target fault.
module instr_fetch #(
    parameter logic [31:0] ResetPc = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic        misalign_o
);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFault = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  kill_cnt_q, kill_cnt_d;
    logic [31:0] fifo_ins_q [2];
    logic [31:0] fifo_pc_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic misaligned, redir_ok, fault_hit, credit_ok;
    logic grant, rsp, push, pop, flush;

    assign misaligned = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    assign redir_ok   = redirect_i & ~misaligned & (state_q != StFault);
    assign fault_hit  = misaligned & (state_q == StRun);
    assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, count_q}) < 3'd2;

    assign imem_req_o  = (state_q == StRun) & ~redirect_i & credit_ok;
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o & imem_gnt_i;
    // Responses with nothing outstanding are stale (e.g. from before a reset).
    assign rsp         = imem_rvalid_i & (outstanding_q != 2'd0);

    assign ins_valid_o = (count_q != 2'd0);
    assign ins_o       = ins_valid_o ? fifo_ins_q[rd_ptr_q] : 32'h0000_0013;
    assign pc_o        = ins_valid_o ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;
    assign pc_plus4_o  = ins_valid_o ? fifo_pc_q[rd_ptr_q] + 32'd4 : 32'h0000_0004;
    assign misalign_o  = (state_q == StFault);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        kill_cnt_d    = kill_cnt_q;
        outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, rsp};
        push          = 1'b0;
        flush         = 1'b0;

        case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = fault_hit ? StFault : StRun;
            StFault: state_d = StFault;
            default: state_d = StBoot;
        endcase

        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;

        // Redirect squashes everything in flight, including a response arriving now.
        if (redir_ok) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            kill_cnt_d = outstanding_q - {1'b0, rsp};
        end else if (fault_hit) begin
            flush      = 1'b1;
            kill_cnt_d = outstanding_q - {1'b0, rsp};
        end else if (rsp) begin
            if (kill_cnt_q != 2'd0) begin
                kill_cnt_d = kill_cnt_q - 2'd1;
            end else if (state_q != StFault) begin
                push      = 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end

        pop      = ins_valid_o & ins_ready_i & ~flush;
        wr_ptr_d = flush ? 1'b0 : wr_ptr_q ^ push;
        rd_ptr_d = flush ? 1'b0 : rd_ptr_q ^ pop;
        count_d  = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StBoot;
            fetch_pc_q    <= ResetPc;
            resp_pc_q     <= ResetPc;
            outstanding_q <= 2'd0;
            kill_cnt_q    <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            fifo_ins_q[0] <= 32'h0;
            fifo_ins_q[1] <= 32'h0;
            fifo_pc_q[0]  <= 32'h0;
            fifo_pc_q[1]  <= 32'h0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (push) begin
                fifo_ins_q[wr_ptr_q] <= imem_rdata_i;
                fifo_pc_q[wr_ptr_q]  <= resp_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: latency-varying memory model, scoreboard of the
// expected in-order PC stream, plus directed reset/stall/redirect/wrap/fault cases.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ins, pc, pc_plus4;
    logic        ins_valid, ins_ready, misalign;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .ins_o         (ins),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .ins_valid_o   (ins_valid),
        .ins_ready_i   (ins_ready),
        .misalign_o    (misalign)
    );

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } mem_t;

    int          total = 0;
    int          bad   = 0;
    int unsigned cycle = 0;
    int unsigned last_due = 0;
    int unsigned lat_lo = 1, lat_hi = 1;
    logic [31:0] key = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] exp_q[$];
    mem_t        mem_q[$];
    bit          fault_armed = 1'b0, fault_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    // Expected decode stream after a (re)start at 'start': consecutive words.
    function automatic void refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 300; i++) exp_q.push_back(start + 32'(4 * i));
    endfunction

    // Memory: in-order responses, at most one per cycle, >= 1 cycle after grant.
    always @(posedge clk) begin
        mem_t m;
        #1;
        cycle++;
        if (mem_q.size() != 0 && mem_q[0].due <= cycle) begin
            m           = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = m.data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        int unsigned lat, due;
        mem_t        m;
        logic [31:0] e;
        if (!rst) begin
            if (redirect) check("req_during_redirect", imem_req, 1'b0);
            if (imem_req && imem_gnt) begin
                check("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                lat = $urandom_range(lat_hi, lat_lo);
                due = cycle + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.data = imem_addr ^ key;
                m.due  = due;
                mem_q.push_back(m);
            end
            if (fault_seen) begin
                check("fault_req", imem_req, 1'b0);
                check("fault_valid", ins_valid, 1'b0);
                check("fault_misalign", misalign, 1'b1);
            end else begin
                check("misalign_clear", misalign, 1'b0);
            end
            if (ins_valid) begin
                if (ins_ready && !redirect) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_unexpected: got pc %h want no pop", pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_pc", pc, e);
                        check("pop_pc_plus4", pc_plus4, e + 32'd4);
                        check("pop_ins", ins, e ^ key);
                    end
                end
            end else begin
                check("idle_ins", ins, 32'h0000_0013);
                check("idle_pc", pc, 32'h0);
                check("idle_pc_plus4", pc_plus4, 32'h4);
            end
            if (fault_armed) fault_seen = 1'b1;
        end
    end

    task automatic drain();
        logic g;
        g        = imem_gnt;
        imem_gnt = 1'b0;
        for (int i = 0; i < 30 && mem_q.size() != 0; i++) @(negedge clk);
        if (mem_q.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
        imem_gnt = g;
    endtask

    task automatic do_reset(input logic [31:0] k);
        rst = 1'b1;
        redirect = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", ins_valid, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        key         = k;
        fault_armed = 1'b0;
        fault_seen  = 1'b0;
        exp_fetch   = 32'h0;
        refill(32'h0);
        rst = 1'b0;
        if (mem_q.size() != 0) drain();
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ins_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    task automatic wait_grant(input string name, input logic [31:0] addr);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && imem_addr == addr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = target;
        refill(target);
        exp_fetch   = target;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    initial begin
        int   grants;
        bit   found;
        logic [31:0] t;
        rst         = 1'b1;
        imem_gnt    = 1'b1;
        ins_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // Boot sequence with 1-cycle memory returning address as data.
        lat_lo = 1;
        lat_hi = 1;
        do_reset(32'h0);
        @(negedge clk);
        check("boot_req", imem_req, 1'b0);
        @(negedge clk);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("resp_not_yet_visible", ins_valid, 1'b0);
        @(negedge clk);
        check("first_valid", ins_valid, 1'b1);
        check("first_ins", ins, 32'h0);
        check("first_pc", pc, 32'h0);
        check("first_pc_plus4", pc_plus4, 32'h4);
        repeat (8) @(negedge clk);

        // Decode stalled: credit caps grants at two.
        ins_ready = 1'b0;
        do_reset($urandom);
        grants = 0;
        repeat (12) begin
            @(negedge clk);
            if (imem_req && imem_gnt) grants++;
        end
        check("stall_grants", grants, 2);
        check("stall_req", imem_req, 1'b0);
        check("stall_valid", ins_valid, 1'b1);
        check("stall_head_pc", pc, 32'h0);
        @(posedge clk);
        #1;
        ins_ready = 1'b1;
        @(posedge clk);
        #1;
        ins_ready = 1'b0;
        @(negedge clk);
        check("stall_next_pc", pc, 32'h4);
        check("stall_req_after_pop", imem_req, 1'b1);
        @(posedge clk);
        #1;
        ins_ready = 1'b1;

        // Redirect with two requests outstanding.
        lat_lo = 3;
        lat_hi = 3;
        do_reset($urandom);
        wait_grant("first_grant", 32'h0);
        @(negedge clk);
        check("second_grant", imem_req & imem_gnt, 1'b1);
        do_redirect(32'h0000_0100);
        wait_valid("redirect_valid");
        check("redirect_pc", pc, 32'h0000_0100);
        check("redirect_pc_plus4", pc_plus4, 32'h0000_0104);

        // Address wrap at the top of memory.
        lat_lo = 1;
        lat_hi = 3;
        do_redirect(32'hFFFF_FFF8);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ins_valid && pc == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
        end
        if (found) check("wrap_pc_plus4", pc_plus4, 32'h0);
        else fail_now("wrap_entry");
        repeat (10) @(negedge clk);

        // Reset with requests in flight; stale responses must be ignored.
        lat_lo = 3;
        lat_hi = 3;
        do_reset($urandom);
        wait_grant("grant_at_4", 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_req", imem_req, 1'b0);
        check("async_rst_valid", ins_valid, 1'b0);
        check("async_rst_pc_plus4", pc_plus4, 32'h4);
        check("async_rst_ins", ins, 32'h0000_0013);
        do_reset($urandom);
        wait_valid("post_reset_valid");
        check("post_reset_pc", pc, 32'h0);
        check("post_reset_ins", ins, key);

        // Randomized traffic with redirects, including back-to-back.
        lat_lo = 1;
        lat_hi = 3;
        for (int n = 0; n < 2500; n++) begin
            @(posedge clk);
            #1;
            imem_gnt  = ($urandom % 4) != 0;
            ins_ready = ($urandom % 3) != 0;
            if ($urandom % 10 == 0) begin
                case ($urandom % 3)
                    0:       t = {$urandom, 2'b00} & 32'hFFFF_FFFC;
                    1:       t = 32'hFFFF_FFF0 + 32'(4 * ($urandom % 4));
                    default: t = 32'(4 * ($urandom % 64));
                endcase
                redirect    = 1'b1;
                redirect_pc = t;
                refill(t);
                exp_fetch   = t;
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        imem_gnt  = 1'b1;
        ins_ready = 1'b1;
        drain();

        // Redirect arriving during the boot cycle.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        fault_armed = 1'b0;
        fault_seen  = 1'b0;
        rst         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        refill(32'h0000_0200);
        exp_fetch   = 32'h0000_0200;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        wait_valid("boot_redirect_valid");
        check("boot_redirect_pc", pc, 32'h0000_0200);
        repeat (6) @(negedge clk);

        // Misaligned redirect: sticky fault until reset.
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        exp_q.delete();
        fault_armed = 1'b1;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        check("misalign_set", misalign, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            imem_gnt  = ($urandom % 2) != 0;
            ins_ready = ($urandom % 2) != 0;
        end
        imem_gnt  = 1'b1;
        ins_ready = 1'b1;

        lat_lo = 1;
        lat_hi = 2;
        do_reset($urandom);
        wait_valid("final_valid");
        check("final_pc", pc, 32'h0);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
